udt_tx_arbiter: RTL and testbench
=================================

Name: udt_tx_arbiter

Overview:
Packet-atomic scheduler that shares the single outbound UDP AXI-Stream (udp_tx_*) between four UDT packet producers: handshake/close, NAK, ACK/ACK2 and DATA.
- Control packets get strict priority.
- DATA gets a guaranteed slot so it cannot be starved.
- Each packet is length-guarded; an over-long packet is truncated and its remainder drained.
- Sits between the SocketManager/Process* packet generators and the udp_tx trans_keep instance inside udt_core.

Parameters:
DATA_WIDTH, 64, stream data width in bits; tkeep width is DATA_WIDTH/8.
MAX_CTRL_BURST, 4, consecutive control packets allowed while DATA waits; range 1..15.
MAX_BEATS, 190, maximum beats per packet before forced truncation; range 2..255.

Ports:
core_clk  input  1  block clock
core_rst_n  input  1  asynchronous active-low reset
s_tdata  input  4*DATA_WIDTH  source i data in bits [64i+63:64i]; i: 0=HS, 1=NAK, 2=ACK, 3=DATA
s_tkeep  input  4*8  source i byte enables in bits [8i+7:8i]
s_tvalid  input  4  per-source valid
s_tlast  input  4  per-source end of packet
s_tready  output  4  per-source ready
m_tdata  output  DATA_WIDTH  to udp_tx path
m_tkeep  output  8  to udp_tx path
m_tvalid  output  1  to udp_tx path
m_tlast  output  1  to udp_tx path
m_tready  input  1  from udp_tx path
data_en  input  1  DATA source eligible (connection established); control sources always eligible
grant  output  2  index of the source currently owning the output
busy  output  1  state != IDLE
pkt_trunc  output  1  one-cycle pulse when a truncation occurs
tx_pkt_cnt  output  32  packets completed on m_*, wraps at 2^32

Behaviour:
- Reset (asynchronous, core_rst_n=0):
  - state=IDLE; grant=0, busy=0, pkt_trunc=0, tx_pkt_cnt=0.
  - ctrl_streak=0, beat_cnt=0.
  - m_tvalid=0 and s_tready=0 immediately, without waiting for a clock edge.
- Reset mid-packet: the partial packet is abandoned. After release, arbitration restarts fresh from IDLE.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - Eligible set: s_tvalid[0..2], plus s_tvalid[3] only when data_en=1.
  - If the set is non-empty, register the winner into grant and go to XFER on the next edge.
  - m_tvalid=0 and all s_tready=0 while in IDLE.
- Winner selection:
  - If DATA is eligible and ctrl_streak==MAX_CTRL_BURST, DATA wins.
  - Otherwise the lowest eligible index wins (HS > NAK > ACK > DATA).
- ctrl_streak update, evaluated at grant time:
  - Control granted while DATA eligible: increment, saturating at MAX_CTRL_BURST.
  - DATA granted, or DATA not eligible: clear to 0.
- XFER:
  - Combinational pass-through: m_tdata/m_tkeep/m_tvalid follow source[grant].
  - s_tready[grant]=m_tready; all other s_tready=0.
  - beat_cnt increments on each m_tvalid&m_tready beat.
  - m_tlast = s_tlast[grant] OR (beat_cnt==MAX_BEATS-1).
- Packet end: on a beat with m_tlast=1:
  - tx_pkt_cnt increments.
  - beat_cnt clears.
  - If s_tlast[grant]=1 → IDLE.
  - Otherwise pkt_trunc pulses and the state goes to DRAIN.
- DRAIN:
  - m_tvalid=0; s_tready[grant]=1 and incoming beats are discarded.
  - On a source beat with s_tlast → IDLE.
- Throughput: one idle bubble cycle between packets.
  - First beat latency from tvalid in IDLE is 1 cycle.
  - A packet of N beats occupies N+1 cycles when m_tready=1.
- data_en falling mid-packet: a granted DATA packet still completes. data_en only gates new grants.
- Source contract: a granted source must keep tvalid/tdata stable until accepted. The arbiter does no reordering and drops nothing except during DRAIN.

Decomposition:
- udt_pkg:
  - localparams SRC_HS=0, SRC_NAK=1, SRC_ACK=2, SRC_DATA=3.
  - State encoding ST_IDLE/ST_XFER/ST_DRAIN.
  - UDT_AXIS_W=64.
- Sub-module udt_tx_pick: combinational winner selection from eligible mask, ctrl_streak and MAX_CTRL_BURST. Outputs winner index and any_eligible.

Test Plan:
1. Priority and atomicity: ACK (3 beats) and DATA (2 beats) valid, data_en=1, m_tready=1 → m_* carries ACK beats 0-2, then 1 bubble, then DATA; grant=2 then 3; tx_pkt_cnt=2.
2. Preemption during packet: HS asserts valid mid-DATA packet → DATA completes uninterrupted; HS is granted only after the bubble following DATA tlast.
3. Starvation guard: NAK continuously valid with 1-beat packets, DATA valid, MAX_CTRL_BURST=4 → grant sequence 1,1,1,1,3,1,1,1,1,3.
4. Truncation: MAX_BEATS=4, DATA source sends 6 beats → m_tlast on the 4th beat, pkt_trunc pulses once, beats 5-6 accepted and not forwarded, then IDLE; tx_pkt_cnt+1.
5. Backpressure and gating: m_tready toggling 1010 → no beat lost or duplicated. data_en=0 with only DATA valid → grant never 3, m_tvalid stays 0.
6. Async reset mid-XFER: core_rst_n low between clock edges → m_tvalid and s_tready go to 0 immediately. After release, a new HS packet transfers cleanly with tx_pkt_cnt=1.

Source files
------------

// File: rtl/udt_pkg.sv
// Shared constants for the UDT transmit path: source indices, the arbiter state
// encoding and the native AXI-Stream width.
package udt_pkg;

    localparam int UDT_AXIS_W = 64;

    localparam logic [1:0] SRC_HS   = 2'd0;
    localparam logic [1:0] SRC_NAK  = 2'd1;
    localparam logic [1:0] SRC_ACK  = 2'd2;
    localparam logic [1:0] SRC_DATA = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } udt_tx_state_e;

endpackage

// File: rtl/udt_tx_pick.sv
// Winner selection for the UDT transmit arbiter: fixed control priority,
// with DATA forced through once the control streak reaches its limit.
module udt_tx_pick
    import udt_pkg::*;
#(
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic [3:0] elig,
    input  logic [3:0] ctrl_streak,
    output logic [1:0] winner,
    output logic       any_eligible
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_CTRL_BURST);

    always_comb begin
        any_eligible = |elig;
        winner       = SRC_DATA;
        if (elig[SRC_DATA] && ctrl_streak == STREAK_MAX) begin
            winner = SRC_DATA;
        end else if (elig[SRC_HS]) begin
            winner = SRC_HS;
        end else if (elig[SRC_NAK]) begin
            winner = SRC_NAK;
        end else if (elig[SRC_ACK]) begin
            winner = SRC_ACK;
        end
    end

endmodule

// File: rtl/udt_tx_arbiter.sv
// Packet-atomic scheduler sharing the outbound UDP stream between the
// handshake, NAK, ACK and DATA packet producers, with per-packet length guard.
module udt_tx_arbiter
    import udt_pkg::*;
#(
    parameter int DATA_WIDTH     = UDT_AXIS_W,
    parameter int MAX_CTRL_BURST = 4,
    parameter int MAX_BEATS      = 190
) (
    input  logic                      core_clk,
    input  logic                      core_rst_n,
    input  logic [4*DATA_WIDTH-1:0]   s_tdata,
    input  logic [4*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [3:0]                s_tvalid,
    input  logic [3:0]                s_tlast,
    output logic [3:0]                s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    input  logic                      data_en,
    output logic [1:0]                grant,
    output logic                      busy,
    output logic                      pkt_trunc,
    output logic [31:0]               tx_pkt_cnt
);

    localparam int         KEEP_W     = DATA_WIDTH / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_CTRL_BURST);
    localparam logic [7:0] LAST_BEAT  = 8'(MAX_BEATS - 1);

    udt_tx_state_e state;
    logic [3:0]    ctrl_streak;
    logic [7:0]    beat_cnt;
    logic [3:0]    elig;
    logic [1:0]    winner;
    logic          any_elig;
    logic          src_last;
    logic          beat;

    assign elig = {s_tvalid[SRC_DATA] & data_en, s_tvalid[2:0]};

    udt_tx_pick #(
        .MAX_CTRL_BURST(MAX_CTRL_BURST)
    ) u_pick (
        .elig        (elig),
        .ctrl_streak (ctrl_streak),
        .winner      (winner),
        .any_eligible(any_elig)
    );

    // Handshake: a beat moves when valid and ready are both high at the clock
    // edge; valid never waits on ready, and ready is driven only to the owner.
    assign src_last = s_tlast[grant];
    assign m_tdata  = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign m_tkeep  = s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
    assign m_tvalid = (state == ST_XFER) && s_tvalid[grant];
    assign m_tlast  = (state == ST_XFER) && (src_last || beat_cnt == LAST_BEAT);
    assign busy     = (state != ST_IDLE);
    assign beat     = m_tvalid && m_tready;

    always_comb begin
        s_tready = '0;
        if (state == ST_XFER) begin
            s_tready[grant] = m_tready;
        end else if (state == ST_DRAIN) begin
            s_tready[grant] = 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state       <= ST_IDLE;
            grant       <= SRC_HS;
            ctrl_streak <= '0;
            beat_cnt    <= '0;
            pkt_trunc   <= 1'b0;
            tx_pkt_cnt  <= '0;
        end else begin
            pkt_trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        grant <= winner;
                        state <= ST_XFER;
                        // The streak only counts control grants that made DATA wait.
                        if (!elig[SRC_DATA] || winner == SRC_DATA) begin
                            ctrl_streak <= '0;
                        end else if (ctrl_streak != STREAK_MAX) begin
                            ctrl_streak <= ctrl_streak + 4'd1;
                        end
                    end
                end
                ST_XFER: begin
                    if (beat) begin
                        if (m_tlast) begin
                            tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
                            beat_cnt   <= '0;
                            if (src_last) begin
                                state <= ST_IDLE;
                            end else begin
                                pkt_trunc <= 1'b1;
                                state     <= ST_DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_tvalid[grant] && src_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// Self-checking bench for udt_tx_arbiter: packet-level source queues, a
// behavioural arbiter model checked every cycle, plus directed literal checks.
module tb_udt_tx_arbiter;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int MCB = 4;
    localparam int MB  = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            core_clk = 1'b0;
    logic            core_rst_n;
    logic [4*DW-1:0] s_tdata;
    logic [4*KW-1:0] s_tkeep;
    logic [3:0]      s_tvalid;
    logic [3:0]      s_tlast;
    logic [3:0]      s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic            data_en;
    logic [1:0]      grant;
    logic            busy;
    logic            pkt_trunc;
    logic [31:0]     tx_pkt_cnt;

    udt_tx_arbiter #(
        .DATA_WIDTH(DW), .MAX_CTRL_BURST(MCB), .MAX_BEATS(MB)
    ) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready),
        .data_en(data_en), .grant(grant), .busy(busy),
        .pkt_trunc(pkt_trunc), .tx_pkt_cnt(tx_pkt_cnt)
    );

    // clock / reset
    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t src_q[4][$];
    bit    acc[4];
    int    out_beats = 0;
    int    trunc_seen = 0;
    int    pushed_total = 0;
    int    dut_grants[$];
    int    model_grants[$];
    int    exp_seq[$];
    bit    prev_busy = 1'b0;

    // packet-level model of the arbiter
    int          md_owner = -1;
    bit          md_drop = 1'b0;
    int          md_grant = 0;
    int          md_streak = 0;
    int          md_beats = 0;
    logic [31:0] md_pkts = '0;
    bit          md_trunc = 1'b0;
    bit          md_next_trunc;
    logic [3:0]  v_s, er_s;
    bit          el_s[4];
    bit          ev_s;
    int          win_s;
    beat_t       hd_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: compare DUT against the model, then advance the model
    always @(negedge core_clk) begin
        if (!core_rst_n) begin
            md_owner = -1; md_drop = 0; md_grant = 0; md_streak = 0;
            md_beats = 0; md_pkts = '0; md_trunc = 0;
            for (int i = 0; i < 4; i++) acc[i] = 0;
            prev_busy = 0;
        end else begin
            v_s  = s_tvalid;
            er_s = '0;
            ev_s = 0;
            if (md_owner >= 0) begin
                er_s[md_owner] = md_drop ? 1'b1 : m_tready;
                ev_s = !md_drop && v_s[md_owner];
            end
            chk("grant", grant, md_grant);
            chk("busy", busy, md_owner >= 0);
            chk("pkt_trunc", pkt_trunc, md_trunc);
            chk("tx_pkt_cnt", tx_pkt_cnt, md_pkts);
            chk("m_tvalid", m_tvalid, ev_s);
            chk("s_tready", s_tready, er_s);
            if (ev_s) begin
                hd_s = src_q[md_owner][0];
                chk("m_tdata", m_tdata, hd_s.data);
                chk("m_tkeep", m_tkeep, hd_s.keep);
                chk("m_tlast", m_tlast, hd_s.last || md_beats == MB - 1);
            end

            for (int i = 0; i < 4; i++) acc[i] = s_tvalid[i] && s_tready[i];
            if (m_tvalid && m_tready) out_beats++;
            if (pkt_trunc) trunc_seen++;
            if (busy && !prev_busy) dut_grants.push_back(int'(grant));
            prev_busy = busy;

            md_next_trunc = 0;
            if (md_owner < 0) begin
                for (int i = 0; i < 3; i++) el_s[i] = v_s[i];
                el_s[3] = v_s[3] && data_en;
                win_s = -1;
                if (el_s[3] && md_streak == MCB) win_s = 3;
                else for (int i = 3; i >= 0; i--) if (el_s[i]) win_s = i;
                if (win_s >= 0) begin
                    if (!el_s[3] || win_s == 3) md_streak = 0;
                    else if (md_streak < MCB) md_streak++;
                    md_owner = win_s; md_grant = win_s; md_drop = 0;
                    model_grants.push_back(win_s);
                end
            end else if (!md_drop) begin
                if (v_s[md_owner] && m_tready) begin
                    hd_s = src_q[md_owner][0];
                    if (hd_s.last || md_beats == MB - 1) begin
                        md_pkts++;
                        md_beats = 0;
                        if (hd_s.last) md_owner = -1;
                        else begin md_drop = 1; md_next_trunc = 1; end
                    end else begin
                        md_beats++;
                    end
                end
            end else if (v_s[md_owner] && src_q[md_owner][0].last) begin
                md_owner = -1;
            end
            md_trunc = md_next_trunc;
        end
    end

    // driver tasks
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = src_q[i].size() > 0;
            if (src_q[i].size() > 0) begin
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tdata[i*DW +: DW] = '0;
                s_tkeep[i*KW +: KW] = '0;
                s_tlast[i]          = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        for (int i = 0; i < 4; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        #1;
        drive();
    endtask

    task automatic push_pkt(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {8'(src), 8'(k), 16'(pushed_total), 32'($urandom)};
            b.last = (k == len - 1);
            b.keep = b.last ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
            src_q[src].push_back(b);
        end
        pushed_total++;
        drive();
    endtask

    function automatic bit queues_empty();
        return src_q[0].size() == 0 && src_q[1].size() == 0 &&
               src_q[2].size() == 0 && src_q[3].size() == 0;
    endfunction

    task automatic wait_idle(input string name, input int budget, output int k);
        k = 0;
        while ((!queues_empty() || busy) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, " dut grant count"}, dut_grants.size(), exp_seq.size());
        chk({name, " model grant count"}, model_grants.size(), exp_seq.size());
        for (int k = 0; k < exp_seq.size(); k++) begin
            if (k < dut_grants.size()) chk({name, " dut grant"}, dut_grants[k], exp_seq[k]);
            if (k < model_grants.size()) chk({name, " model grant"}, model_grants[k], exp_seq[k]);
        end
        dut_grants.delete();
        model_grants.delete();
    endtask

    int cyc, nv, ng3, base_pkts;

    initial begin
        core_rst_n = 1'b0;
        m_tready   = 1'b0;
        data_en    = 1'b0;
        drive();
        repeat (3) @(posedge core_clk);
        #1;
        chk("reset m_tvalid", m_tvalid, 0);
        chk("reset s_tready", s_tready, 0);
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset pkt_trunc", pkt_trunc, 0);
        chk("reset tx_pkt_cnt", tx_pkt_cnt, 0);
        core_rst_n = 1'b1;
        step();

        // priority and atomicity
        data_en = 1; m_tready = 1; out_beats = 0;
        push_pkt(2, 3); push_pkt(3, 2);
        wait_idle("A", 50, cyc);
        chk("A cycles", cyc, 7);
        chk("A beats", out_beats, 5);
        chk("A tx_pkt_cnt", tx_pkt_cnt, 2);
        exp_seq = {2, 3};
        check_seq("A");

        // starvation guard
        for (int k = 0; k < 8; k++) push_pkt(1, 1);
        push_pkt(3, 1); push_pkt(3, 1);
        wait_idle("B", 100, cyc);
        chk("B cycles", cyc, 20);
        chk("B tx_pkt_cnt", tx_pkt_cnt, 12);
        exp_seq = {1, 1, 1, 1, 3, 1, 1, 1, 1, 3};
        check_seq("B");

        // truncation
        trunc_seen = 0; out_beats = 0;
        push_pkt(3, 6);
        wait_idle("C", 50, cyc);
        chk("C cycles", cyc, 7);
        chk("C trunc pulses", trunc_seen, 1);
        chk("C beats", out_beats, 4);
        chk("C tx_pkt_cnt", tx_pkt_cnt, 13);
        dut_grants.delete(); model_grants.delete();

        // preemption attempt mid-packet
        push_pkt(3, 3);
        step(); step();
        push_pkt(0, 2);
        wait_idle("D", 50, cyc);
        chk("D cycles", cyc, 5);
        chk("D tx_pkt_cnt", tx_pkt_cnt, 15);
        exp_seq = {3, 0};
        check_seq("D");

        // data_en gating
        data_en = 0; out_beats = 0; nv = 0; ng3 = 0;
        push_pkt(3, 2);
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_tvalid) nv++;
            if (grant == 2'd3) ng3++;
        end
        chk("E m_tvalid cycles", nv, 0);
        chk("E grant3 cycles", ng3, 0);
        chk("E beats", out_beats, 0);
        data_en = 1;
        wait_idle("E", 50, cyc);
        chk("E tx_pkt_cnt", tx_pkt_cnt, 16);

        // 1010 backpressure
        out_beats = 0;
        push_pkt(3, 3); push_pkt(2, 2);
        for (int k = 0; k < 60 && (!queues_empty() || busy); k++) begin
            m_tready = ~m_tready;
            step();
        end
        m_tready = 1;
        wait_idle("F", 20, cyc);
        chk("F beats", out_beats, 5);
        chk("F tx_pkt_cnt", tx_pkt_cnt, 18);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) data_en = ~data_en;
            for (int i = 0; i < 4; i++)
                if (src_q[i].size() == 0 && $urandom_range(0, 4) == 0)
                    push_pkt(i, $urandom_range(1, 6));
            step();
        end
        data_en = 1; m_tready = 1;
        wait_idle("G", 1000, cyc);
        chk("G total packets", tx_pkt_cnt, pushed_total);

        // async reset mid-transfer
        m_tready = 0;
        push_pkt(3, 3);
        step(); step();
        chk("H pre-reset m_tvalid", m_tvalid, 1);
        #2;
        core_rst_n = 1'b0;
        #1;
        chk("H reset m_tvalid", m_tvalid, 0);
        chk("H reset s_tready", s_tready, 0);
        chk("H reset busy", busy, 0);
        chk("H reset tx_pkt_cnt", tx_pkt_cnt, 0);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        drive();
        step(); step();
        core_rst_n = 1'b1;
        dut_grants.delete(); model_grants.delete();
        m_tready = 1; out_beats = 0;
        push_pkt(0, 2);
        wait_idle("H", 50, cyc);
        chk("H beats", out_beats, 2);
        chk("H tx_pkt_cnt", tx_pkt_cnt, 1);
        exp_seq = {0};
        check_seq("H");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
